// File: rtl/sb_rx_deserializer_if.sv
// Sideband receive bundle: serial pin and forwarded-clock qualifier in, frame FIFO head out.
// The deserializer connects through the slave modport and its driver through master.
interface sb_rx_deserializer_if;
   logic        dataPin_i;
   logic        clkValid_i;
   logic [63:0] data_o;
   logic        valid_o;
   logic        ready_i;
   logic        overflow_o;
   logic        frameErr_o;

   modport master (
      output dataPin_i, clkValid_i, ready_i,
      input  data_o, valid_o, overflow_o, frameErr_o
   );

   modport slave (
      input  dataPin_i, clkValid_i, ready_i,
      output data_o, valid_o, overflow_o, frameErr_o
   );
endinterface

// File: rtl/sb_rx_deserializer.sv
// Sideband receive deserializer: collects 64 UIs LSB first, polices the 32-UI low gap,
// and queues completed frames in a small FIFO for the message decoder.
module sb_rx_deserializer #(
   parameter int buffer_size = 4
) (
   input  logic              clk_800MHz,
   input  logic              reset,
   sb_rx_deserializer_if.slave sb
);
   localparam int IDX_W = $clog2(buffer_size);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(buffer_size);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [5:0]       bitcnt_q, bitcnt_d;
   logic [4:0]       gapcnt_q, gapcnt_d;
   // Bit 63 never lands here: it is merged straight into the pushed word.
   logic [62:0]      shift_q, shift_d;
   logic [63:0]      buffer_q [buffer_size];
   logic [63:0]      buffer_d [buffer_size];
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             frame_err_q, frame_err_d;

   logic             push_s;
   logic             pop_s;
   logic             full_s;
   logic             push_ok_s;
   logic [63:0]      push_data_s;

   assign sb.data_o     = buffer_q[rd_idx_q];
   assign sb.valid_o    = (count_q != {CNT_W{1'b0}});
   assign sb.overflow_o = overflow_q;
   assign sb.frameErr_o = frame_err_q;

   // Framing FSM: next state, bit/gap counters, shift register and push request.
   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      gapcnt_d    = gapcnt_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push_s      = 1'b0;
      push_data_s = {sb.dataPin_i, shift_q};
      case (state_q)
         ST_IDLE: begin
            gapcnt_d = 5'd0;
            if (sb.clkValid_i) begin
               shift_d  = {62'd0, sb.dataPin_i};
               bitcnt_d = 6'd1;
               state_d  = ST_RECV;
            end else begin
               bitcnt_d = 6'd0;
            end
         end
         ST_RECV: begin
            if (!sb.clkValid_i) begin
               frame_err_d = (bitcnt_q != 6'd0);
               bitcnt_d    = 6'd0;
               state_d     = ST_IDLE;
            end else if (bitcnt_q == 6'd63) begin
               push_s   = 1'b1;
               bitcnt_d = 6'd0;
               gapcnt_d = 5'd0;
               state_d  = ST_GAP;
            end else begin
               shift_d[bitcnt_q] = sb.dataPin_i;
               bitcnt_d          = bitcnt_q + 6'd1;
            end
         end
         ST_GAP: begin
            if (!sb.clkValid_i) begin
               gapcnt_d = 5'd0;
               state_d  = ST_IDLE;
            end else begin
               frame_err_d = sb.dataPin_i;
               if (gapcnt_q == 5'd31) begin
                  gapcnt_d = 5'd0;
                  bitcnt_d = 6'd0;
                  state_d  = ST_RECV;
               end else begin
                  gapcnt_d = gapcnt_q + 5'd1;
               end
            end
         end
         default: begin
            bitcnt_d = 6'd0;
            gapcnt_d = 5'd0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // FIFO bookkeeping: a push into a full FIFO survives only if a pop frees a slot on the same edge.
   always_comb begin
      buffer_d   = buffer_q;
      wr_idx_d   = wr_idx_q;
      rd_idx_d   = rd_idx_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      pop_s      = sb.valid_o && sb.ready_i;
      full_s     = (count_q == FULL_CNT);
      push_ok_s  = push_s && (!full_s || pop_s);
      if (push_s && full_s && !pop_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
      if (push_ok_s) begin
         buffer_d[wr_idx_q] = push_data_s;
         wr_idx_d           = wr_idx_q + IDX_W'(1);
      end else begin
         wr_idx_d = wr_idx_q;
      end
      if (pop_s) begin
         rd_idx_d = rd_idx_q + IDX_W'(1);
      end else begin
         rd_idx_d = rd_idx_q;
      end
      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State and storage registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk_800MHz or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bitcnt_q    <= 6'd0;
         gapcnt_q    <= 5'd0;
         shift_q     <= 63'd0;
         wr_idx_q    <= {IDX_W{1'b0}};
         rd_idx_q    <= {IDX_W{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < buffer_size; i++) begin
            buffer_q[i] <= 64'd0;
         end
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         gapcnt_q    <= gapcnt_d;
         shift_q     <= shift_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
         buffer_q    <= buffer_d;
      end
   end
endmodule

// File: tb/tb_sb_rx_deserializer.sv
// Directed bench for sb_rx_deserializer: a table of single frames plus hand-written
// sequences for back-to-back wrap, overflow, truncation, gap violation and mid-frame reset.
module tb_sb_rx_deserializer;
   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   err_pulses;

   sb_rx_deserializer_if sb_if ();

   sb_rx_deserializer #(.buffer_size(4)) dut (
      .clk_800MHz (clk),
      .reset      (rst),
      .sb         (sb_if)
   );

   typedef struct {
      logic [63:0] frame;
      logic        exp_valid;
      logic [63:0] exp_data;
   } vec_t;

   vec_t vecs [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // frameErr_o is held for a whole cycle, so exactly one falling edge sees each pulse.
   initial err_pulses = 0;
   always @(negedge clk) begin
      if (sb_if.frameErr_o === 1'b1) err_pulses <= err_pulses + 1;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sb_if.clkValid_i = 1'b1;
      sb_if.dataPin_i  = b;
      tick();
   endtask

   task automatic idle_cycles(input int n);
      sb_if.clkValid_i = 1'b0;
      sb_if.dataPin_i  = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_data(input logic [63:0] f);
      for (int i = 0; i < 64; i++) send_bit(f[i]);
   endtask

   task automatic send_gap();
      for (int i = 0; i < 32; i++) send_bit(1'b0);
   endtask

   task automatic pop_one();
      sb_if.ready_i = 1'b1;
      tick();
      sb_if.ready_i = 1'b0;
   endtask

   initial begin
      logic [63:0] f;
      logic [63:0] exp_q [4];
      int          e0;
      total = 0;
      bad   = 0;
      vecs[0] = '{64'hA5A5_0000_FFFF_1234, 1'b1, 64'hA5A5_0000_FFFF_1234};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[2] = '{64'h8000_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0001};
      vecs[3] = '{64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000};

      rst = 1'b1;
      sb_if.dataPin_i  = 1'b0;
      sb_if.clkValid_i = 1'b0;
      sb_if.ready_i    = 1'b0;
      repeat (3) tick();
      check("rst_valid", 64'(sb_if.valid_o), 64'd0);
      check("rst_data", sb_if.data_o, 64'd0);
      check("rst_overflow", 64'(sb_if.overflow_o), 64'd0);
      check("rst_frameerr", 64'(sb_if.frameErr_o), 64'd0);
      rst = 1'b0;
      tick();

      // Single frames into an empty FIFO: valid_o must rise right after edge 64.
      for (int v = 0; v < 4; v++) begin
         e0 = err_pulses;
         for (int i = 0; i < 64; i++) begin
            send_bit(vecs[v].frame[i]);
            if (i == 62) check("vec_early_valid", 64'(sb_if.valid_o), 64'd0);
         end
         check("vec_valid", 64'(sb_if.valid_o), 64'(vecs[v].exp_valid));
         check("vec_data", sb_if.data_o, vecs[v].exp_data);
         send_gap();
         idle_cycles(1);
         check("vec_no_err", 64'(err_pulses - e0), 64'd0);
         pop_one();
         check("vec_popped", 64'(sb_if.valid_o), 64'd0);
      end

      // Six back-to-back frames with ready held high; indices wrap past 3.
      sb_if.ready_i = 1'b1;
      e0 = err_pulses;
      for (int k = 1; k <= 6; k++) begin
         f = 64'(k);
         send_data(f);
         check("b2b_valid", 64'(sb_if.valid_o), 64'd1);
         check("b2b_data", sb_if.data_o, f);
         send_bit(1'b0);
         check("b2b_drained", 64'(sb_if.valid_o), 64'd0);
         for (int i = 1; i < 32; i++) send_bit(1'b0);
      end
      idle_cycles(1);
      sb_if.ready_i = 1'b0;
      check("b2b_overflow", 64'(sb_if.overflow_o), 64'd0);
      check("b2b_no_err", 64'(err_pulses - e0), 64'd0);

      // Overflow: five frames into a depth-4 FIFO, then push+pop on one edge while full.
      for (int k = 0; k < 5; k++) begin
         f = 64'h10 + 64'(k);
         send_data(f);
         if (k == 3) check("ovf_not_yet", 64'(sb_if.overflow_o), 64'd0);
         if (k == 4) check("ovf_set", 64'(sb_if.overflow_o), 64'd1);
         send_gap();
      end
      check("ovf_head", sb_if.data_o, 64'h10);
      f = 64'h15;
      for (int i = 0; i < 63; i++) send_bit(f[i]);
      sb_if.ready_i = 1'b1;
      send_bit(f[63]);
      sb_if.ready_i = 1'b0;
      check("ovf_swap_head", sb_if.data_o, 64'h11);
      send_gap();
      idle_cycles(1);
      exp_q[0] = 64'h11;
      exp_q[1] = 64'h12;
      exp_q[2] = 64'h13;
      exp_q[3] = 64'h15;
      for (int k = 0; k < 4; k++) begin
         check("ovf_drain_valid", 64'(sb_if.valid_o), 64'd1);
         check("ovf_drain_data", sb_if.data_o, exp_q[k]);
         pop_one();
      end
      check("ovf_empty", 64'(sb_if.valid_o), 64'd0);
      check("ovf_sticky", 64'(sb_if.overflow_o), 64'd1);

      // Truncated frame: clock stops after 20 bits.
      e0 = err_pulses;
      f = 64'h0123_4567_89AB_CDEF;
      for (int i = 0; i < 20; i++) send_bit(f[i]);
      idle_cycles(1);
      check("trunc_err_hi", 64'(sb_if.frameErr_o), 64'd1);
      tick();
      check("trunc_err_lo", 64'(sb_if.frameErr_o), 64'd0);
      check("trunc_no_push", 64'(sb_if.valid_o), 64'd0);
      check("trunc_one_pulse", 64'(err_pulses - e0), 64'd1);
      send_data(64'hDEAD_BEEF);
      check("trunc_next_valid", 64'(sb_if.valid_o), 64'd1);
      check("trunc_next_data", sb_if.data_o, 64'hDEAD_BEEF);
      send_gap();
      idle_cycles(1);
      pop_one();

      // Gap violation at UI 10; the next frame must still land on the 96-edge period.
      e0 = err_pulses;
      send_data(64'h1111_2222_3333_4444);
      for (int i = 0; i < 32; i++) begin
         send_bit(i == 10);
         if (i == 10) check("gap_err_hi", 64'(sb_if.frameErr_o), 64'd1);
         if (i == 11) check("gap_err_lo", 64'(sb_if.frameErr_o), 64'd0);
      end
      send_data(64'h5555_6666_7777_8888);
      check("gap_kept", sb_if.data_o, 64'h1111_2222_3333_4444);
      send_gap();
      idle_cycles(1);
      check("gap_one_pulse", 64'(err_pulses - e0), 64'd1);
      pop_one();
      check("gap_next_data", sb_if.data_o, 64'h5555_6666_7777_8888);
      pop_one();
      check("gap_empty", 64'(sb_if.valid_o), 64'd0);

      // Reset in the middle of a frame with two frames queued.
      send_data(64'h21);
      send_gap();
      send_data(64'h22);
      send_gap();
      f = 64'hCAFE_BABE_0000_FFFF;
      for (int i = 0; i < 40; i++) send_bit(f[i]);
      check("rstmid_queued", sb_if.data_o, 64'h21);
      #2;
      rst = 1'b1;
      #1;
      check("rstmid_valid", 64'(sb_if.valid_o), 64'd0);
      check("rstmid_data", sb_if.data_o, 64'd0);
      check("rstmid_overflow", 64'(sb_if.overflow_o), 64'd0);
      idle_cycles(2);
      rst = 1'b0;
      idle_cycles(2);
      e0 = err_pulses;
      send_data(64'hCAFE);
      check("rstmid_new_valid", 64'(sb_if.valid_o), 64'd1);
      check("rstmid_new_data", sb_if.data_o, 64'hCAFE);
      send_gap();
      idle_cycles(1);
      check("rstmid_no_err", 64'(err_pulses - e0), 64'd0);
      pop_one();
      check("rstmid_empty", 64'(sb_if.valid_o), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sb_rx_deserializer.md
# sb_rx_deserializer

Sideband receive deserializer: samples the serial sideband data pin one bit per clock while the link partner's forwarded clock is active, reassembles 64-bit frames LSB first, and queues them in a small FIFO for the sideband message decoder. It sits directly downstream of the sideband transmit serializer, across the link. Framing matches the transmit side: 64 data UIs, then 32 gap UIs held low, then either the next frame or clock stop.

## Interface
- `buffer_size`, 4: FIFO depth in frames; must be a power of 2 and >1.
- `clk_800MHz`  in  1  sole clock; every register is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dataPin_i`  in  1  serial sideband data, already retimed into `clk_800MHz`.
- `clkValid_i`  in  1  high while the partner's forwarded sideband clock toggles; low when that clock is parked in idle.
- `data_o`  out  64  head-of-FIFO frame; bit n is the n-th received UI.
- `valid_o`  out  1  FIFO non-empty.
- `ready_i`  in  1  consumer accepts `data_o` on a rising edge with `valid_o && ready_i`.
- `overflow_o`  out  1  sticky; set when a completed frame is dropped because the FIFO is full.
- `frameErr_o`  out  1  single-cycle pulse on a framing violation.

## Operation
- State machine:
  - **IDLE**: `bitcnt` = 0, `gapcnt` = 0.
    - On a sampled `clkValid_i` = 1, capture `dataPin_i` as bit 0 and go to RECV with `bitcnt` = 1.
  - **RECV**: on each edge with `clkValid_i` = 1, shift `dataPin_i` into bit position `bitcnt` and increment `bitcnt`.
    - When bit 63 is sampled, push {bit63, bits62..0} into the FIFO on that same edge, clear `bitcnt`, and go to GAP.
  - **GAP**: count 32 edges. On each, `dataPin_i` must be 0.
    - After the 32nd gap edge, go to RECV with `bitcnt` = 0.
- Boundary and error handling:
  - RECV with `clkValid_i` = 0 and `bitcnt` = 0: normal end of burst. Go to IDLE with no error.
  - RECV with `clkValid_i` = 0 and `bitcnt` > 0: truncated frame. Pulse `frameErr_o`, discard the partial word, go to IDLE.
  - GAP with `dataPin_i` = 1: pulse `frameErr_o` and stay in GAP. The already-pushed frame is kept.
  - GAP with `clkValid_i` = 0: go to IDLE with no error, and reset `gapcnt`.
- FIFO:
  - Storage is `buffer_size` × 64 bits, with `write_index` and `read_index` each `$clog2(buffer_size)` bits wide. Both indices wrap naturally at `buffer_size`.
  - An occupancy counter of `$clog2(buffer_size)+1` bits distinguishes full from empty.
  - `data_o` is driven combinationally from `buffer[read_index]`; `valid_o` = (count != 0).
  - A pop occurs on an edge where `valid_o && ready_i`.
  - A push while full is dropped and sets `overflow_o`. The exception is a simultaneous pop on the same edge: the push is accepted and the count stays at `buffer_size`.
  - A push and a pop on the same edge when not full leave the count unchanged.
- Reset (asynchronous, at any time including mid-frame or mid-gap):
  - State returns to IDLE; all counters, indices and the shift register go to 0.
  - Buffer contents are cleared to 0, so `data_o` = 0.
  - `valid_o`, `overflow_o` and `frameErr_o` go to 0.
  - Any partial frame is lost.

## Timing
- First bit (bit 0) is sampled on the first rising edge at which `clkValid_i` = 1.
- A frame occupies exactly 64 consecutive sampling edges. Bit 63 is on edge 64.
- Latency:
  - Into an empty FIFO, `valid_o` rises in the cycle after edge 64.
  - Back-to-back frame period is 96 edges (64 data + 32 gap).
- `frameErr_o` is high for exactly one cycle, namely the cycle following the offending edge.
- `overflow_o` stays high until reset.
- Consumer throughput is one frame per cycle. `ready_i` may be held high permanently.

## Test plan
- **Single frame**:
  - Stimulus: `clkValid_i` high for 96 cycles, then low; serial data 64'hA5A5_0000_FFFF_1234 LSB first, then 32 zeros.
  - Required response: `valid_o` rises the cycle after edge 64 with that `data_o`; one `ready_i` pulse pops it; `valid_o` = 0; no `frameErr_o`; state back to IDLE.
- **Back-to-back and wrap**:
  - Stimulus: 6 consecutive frames 64'h1 … 64'h6 with `ready_i` = 1.
  - Required response: frames appear in order, indices wrap past 3 with no loss, `overflow_o` = 0.
- **Overflow**:
  - Stimulus: `ready_i` = 0, 5 frames 64'h10 … 64'h14.
  - Required response: the FIFO holds 64'h10–13, `overflow_o` = 1 after the 5th frame completes, 64'h14 is dropped.
  - Then raise `ready_i` while a 6th frame completes: the push and pop on the same edge both succeed.
- **Truncated frame**:
  - Stimulus: drop `clkValid_i` after 20 bits.
  - Required response: one-cycle `frameErr_o`, no push, IDLE.
  - A following full frame 64'hDEAD_BEEF is received correctly.
- **Gap violation**:
  - Stimulus: drive `dataPin_i` = 1 at gap UI 10.
  - Required response: the stored frame is intact, `frameErr_o` pulses once, and the next frame is still received at period 96.
- **Reset mid-frame**:
  - Stimulus: assert `reset` at bit 40 with 2 frames queued.
  - Required response: immediately `valid_o` = 0, `data_o` = 0, `overflow_o` = 0; after deassert, a new frame 64'hCAFE is received cleanly.
